pwm_meter: RTL
==============

// Module: pwm_meter
// PURPOSE
//  Receive-side counterpart of the PWM generator: measures an incoming PWM waveform
//  in system-clock cycles and reports period, high time and integer duty cycle (0-100 %).
//  Sits on the input pin side; results feed the display and self-check logic.
//  Timeouts on a static (0 % / 100 %) input so a missing signal is always reported.
// PARAMETERS
//  CLK_HZ       50_000_000  system clock frequency, documentation/default sizing only
//  CNT_W        32          width of period / high-time counters and outputs
//  TIMEOUT_CYC  5_000_000   cycles without a rising edge before no_signal (100 ms @ 50 MHz);
//                           must be < 2**CNT_W - 1
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst         in   1      asynchronous reset, active-low (rst = 0 resets)
//  pwm_in      in   1      asynchronous PWM input
//  period      out  CNT_W  last measured period, clk cycles (rise to rise)
//  high_time   out  CNT_W  last measured high time, clk cycles (rise to fall)
//  duty_pct    out  7      floor(100*high_time/period), 0..100
//  valid       out  1      1-cycle pulse: period/high_time/duty_pct/no_signal just updated
//  no_signal   out  1      high while input static longer than TIMEOUT_CYC
//  overrun     out  1      1-cycle pulse: measurement dropped, divider busy
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, FSM IDLE, divider aborted; applies mid-operation.
//  - Input: 2-FF synchronizer -> pwm_s; pwm_d = pwm_s delayed 1 cycle.
//    rise = pwm_s & ~pwm_d, fall = ~pwm_s & pwm_d. Pin-to-edge latency 3 clk.
//  - cnt_per: on rise <= 1, else +1, saturating at all-ones. Rises N cycles apart -> N.
//  - cnt_hi: on rise <= 1; +1 while pwm_s=1 (saturating); on fall hi_lat <= cnt_hi.
//  - FSM states:
//    IDLE: wait for rise -> MEAS (first rise only arms, no result).
//    MEAS: on rise: cap_per <= cnt_per, cap_hi <= hi_lat, -> DIV.
//    DIV : restoring divide of (cap_hi*100) by cap_per, one quotient bit per cycle,
//          CNT_W+7 cycles; on completion load period, high_time, duty_pct, pulse valid,
//          clear no_signal, -> MEAS.
//          A rise while in DIV: measurement discarded, overrun pulses same cycle,
//          divider continues; counters restart normally from that rise.
//  - Result = 100 when high_time = period is impossible by construction; if
//    cap_hi > cap_per (saturation corner) duty_pct clamps to 100.
//  - Timeout: when cnt_per reaches TIMEOUT_CYC (any state except already timed out):
//    abort divider, period <= 0, high_time <= 0, duty_pct <= (pwm_s ? 100 : 0),
//    no_signal <= 1, valid pulses once, FSM -> IDLE. No further valid until the
//    next completed measurement (needs two rises). Simultaneous rise and timeout:
//    rise wins (cnt_per restarts, no timeout).
//  - Divider quotient truncates (floor). Outputs hold between valid pulses.
//  - Minimum measurable period: CNT_W+8 cycles; shorter periods yield overrun pulses.
// TESTING
//  1 period 200, high 50 cycles, 4 periods -> period=200, high_time=50, duty_pct=25,
//    valid once per period, valid CNT_W+7 cycles after 2nd rise (+3 sync).
//  2 period 3000, high 1000 -> duty_pct=33 (floor); then high 2250 -> duty_pct=75
//    on first period after change.
//  3 pwm_in held 1 (TIMEOUT_CYC=1000) -> after 1000 cycles no_signal=1, duty_pct=100,
//    period=0, single valid; held 0 -> duty_pct=0. PWM restored -> no_signal clears
//    at first valid.
//  4 period 20 cycles (< CNT_W+8) -> overrun pulses on alternate rises, measured
//    results still exactly period=20.
//  5 rst=0 mid-DIV -> all outputs 0 next edge-independent; after release, first rise
//    only arms, first valid after second rise.
//  6 glitch narrower than 1 clk on pwm_in -> no spurious valid; rise coincident with
//    timeout cycle -> no_signal stays 0.

Source files
------------

// File: rtl/pwm_meter.sv
// Measures an asynchronous PWM input in clk cycles: period, high time and floor duty cycle.
// Results land CNT_W+7 cycles after the closing rise; a static input is reported via no_signal.
module pwm_meter #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = CLK_HZ / 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [6:0]       duty_pct,
  output logic             valid,
  output logic             no_signal,
  output logic             overrun
);
  localparam int QW = CNT_W + 7;
  localparam int BW = $clog2(QW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, MEAS, DIV} state_t;

  state_t           state_q, state_d;
  logic             sync_q, sync_d, pwm_s_q, pwm_s_d, pwm_d_q, pwm_d_d;
  logic [CNT_W-1:0] cnt_per_q, cnt_per_d, cnt_hi_q, cnt_hi_d, hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] cap_per_q, cap_per_d, cap_hi_q, cap_hi_d;
  logic [QW-1:0]    dvd_q, dvd_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [5:0]       quo_q, quo_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic [6:0]       duty_q, duty_d;
  logic             valid_q, valid_d, nosig_q, nosig_d, ovr_q, ovr_d;

  logic             rise, fall, tmo, ge;
  logic [CNT_W:0]   rem_sh, diff;
  logic [6:0]       quo_nx;

  always_comb begin
    rise   = pwm_s_q & ~pwm_d_q;
    fall   = ~pwm_s_q & pwm_d_q;
    // a rise in the same cycle as the timeout count restarts the counter instead
    tmo    = (cnt_per_q == TMO) && !rise && !nosig_q;
    rem_sh = {rem_q, dvd_q[QW-1]};
    diff   = rem_sh - {1'b0, cap_per_q};
    ge     = ~diff[CNT_W];
    quo_nx = {quo_q, ge};
  end

  always_comb begin
    sync_d    = pwm_in;
    pwm_s_d   = sync_q;
    pwm_d_d   = pwm_s_q;
    state_d   = state_q;
    cap_per_d = cap_per_q;
    cap_hi_d  = cap_hi_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    bit_cnt_d = bit_cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    duty_d    = duty_q;
    nosig_d   = nosig_q;
    valid_d   = 1'b0;
    ovr_d     = 1'b0;
    hi_lat_d  = fall ? cnt_hi_q : hi_lat_q;

    if (rise)                      cnt_per_d = CNT_W'(1);
    else if (cnt_per_q != CNT_MAX) cnt_per_d = cnt_per_q + CNT_W'(1);
    else                           cnt_per_d = cnt_per_q;

    if (rise)                                 cnt_hi_d = CNT_W'(1);
    else if (pwm_s_q && cnt_hi_q != CNT_MAX)  cnt_hi_d = cnt_hi_q + CNT_W'(1);
    else                                      cnt_hi_d = cnt_hi_q;

    if (tmo) begin
      state_d  = IDLE;
      period_d = '0;
      high_d   = '0;
      duty_d   = pwm_s_q ? 7'd100 : 7'd0;
      nosig_d  = 1'b1;
      valid_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (rise) state_d = MEAS;
        MEAS: begin
          if (rise) begin
            cap_per_d = cnt_per_q;
            cap_hi_d  = hi_lat_q;
            dvd_d     = QW'(hi_lat_q) * QW'(100);
            rem_d     = '0;
            quo_d     = '0;
            bit_cnt_d = BW'(QW - 1);
            state_d   = DIV;
          end
        end
        DIV: begin
          rem_d     = ge ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
          quo_d     = quo_nx[5:0];
          dvd_d     = {dvd_q[QW-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - BW'(1);
          ovr_d     = rise;
          if (bit_cnt_q == '0) begin
            period_d = cap_per_q;
            high_d   = cap_hi_q;
            duty_d   = (cap_hi_q > cap_per_q) ? 7'd100 : quo_nx;
            nosig_d  = 1'b0;
            valid_d  = 1'b1;
            state_d  = MEAS;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sync_q    <= 1'b0;
      pwm_s_q   <= 1'b0;
      pwm_d_q   <= 1'b0;
      cnt_per_q <= '0;
      cnt_hi_q  <= '0;
      hi_lat_q  <= '0;
      cap_per_q <= '0;
      cap_hi_q  <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      bit_cnt_q <= '0;
      period_q  <= '0;
      high_q    <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      nosig_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      pwm_s_q   <= pwm_s_d;
      pwm_d_q   <= pwm_d_d;
      cnt_per_q <= cnt_per_d;
      cnt_hi_q  <= cnt_hi_d;
      hi_lat_q  <= hi_lat_d;
      cap_per_q <= cap_per_d;
      cap_hi_q  <= cap_hi_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      bit_cnt_q <= bit_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      duty_q    <= duty_d;
      valid_q   <= valid_d;
      nosig_q   <= nosig_d;
      ovr_q     <= ovr_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign duty_pct  = duty_q;
  assign valid     = valid_q;
  assign no_signal = nosig_q;
  assign overrun   = ovr_q;
endmodule
